// File: rtl/microcode_sequencer.sv
// microcode_sequencer: registers the microcode control word and computes the next microcode address.
// Define USEQ_TRACE_EN to add the trace_cycles / trace_last_target debug outputs.
module microcode_sequencer #(
    parameter int U_ADDR_W = 14,
    parameter int CW_W = 112,
    parameter logic [U_ADDR_W-1:0] FETCH_UADDR = '0,
    parameter logic [U_ADDR_W-1:0] INT_UADDR = U_ADDR_W'(16)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CW_W-1:0]     rom_cw,
    input  logic [7:0]          ir,
    input  logic [3:0]          alu_flags,
    input  logic [3:0]          u_flags,
    input  logic [7:0]          cpu_status,
    input  logic                irq_req,
    input  logic                dma_req,
    input  logic                mem_wait,
    output logic [U_ADDR_W-1:0] u_addr,
    output logic [CW_W-1:0]     cw,
    output logic                dma_ack,
    output logic                halted
`ifdef USEQ_TRACE_EN
    ,
    output logic [31:0]         trace_cycles,
    output logic [U_ADDR_W-1:0] trace_last_target
`endif
);
    typedef enum logic [1:0] {RUN, STALL, HALT, DMA} state_t;

    state_t              state_q;
    logic [U_ADDR_W-1:0] u_addr_q, u_addr_d, rel, disp;
    logic [CW_W-1:0]     cw_q;
    logic                dma_ack_q, halted_q;
    logic [1:0]          typ;
    logic [3:0]          fs;
    logic [15:0]         sel_vec;
    logic                irq_ok, cond, hold;

    always_comb begin
        typ = cw_q[1:0];
        fs = cw_q[10] ? u_flags : alu_flags;
        irq_ok = irq_req & cpu_status[1];
        sel_vec = {6'b0, irq_ok, cpu_status[4], dma_req, fs[1] | fs[0],
                   fs[0] | (fs[2] ^ fs[3]), fs[2] ^ fs[3], fs[3], fs[2], fs[1], fs[0]};
        cond = sel_vec[cw_q[14:11]] ^ cw_q[9];
        rel = u_addr_q + {{(U_ADDR_W-7){cw_q[8]}}, cw_q[8:2]};
        // at the minimum width the escape bit takes the place of ir[7]
        disp = U_ADDR_W'({cw_q[15], ir, 6'b0});
        if (U_ADDR_W == 14) disp[U_ADDR_W-1] = cw_q[15];
        hold = mem_wait & (cw_q[54] | cw_q[55]);
        u_addr_d = typ == 2'b00 ? rel :
                   typ == 2'b01 ? (cond ? rel : u_addr_q + U_ADDR_W'(1)) :
                   typ == 2'b10 ? (irq_ok ? INT_UADDR : FETCH_UADDR) : disp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            u_addr_q <= FETCH_UADDR;
            cw_q <= '0;
            dma_ack_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                RUN, STALL: begin
                    if (hold) begin
                        state_q <= STALL;
                    end else if (typ == 2'b10 && dma_req) begin
                        state_q <= DMA;
                        dma_ack_q <= 1'b1;
                        cw_q <= '0;
                        u_addr_q <= FETCH_UADDR;
                    end else if (typ == 2'b10 && !irq_ok && cpu_status[4]) begin
                        state_q <= HALT;
                        halted_q <= 1'b1;
                        cw_q <= '0;
                        u_addr_q <= FETCH_UADDR;
                    end else begin
                        state_q <= RUN;
                        cw_q <= rom_cw;
                        u_addr_q <= u_addr_d;
                    end
                end
                HALT: begin
                    // cw stays zero on exit: a zero word re-reads the new address without moving
                    if (irq_ok || !cpu_status[4]) begin
                        state_q <= RUN;
                        halted_q <= 1'b0;
                        u_addr_q <= irq_ok ? INT_UADDR : FETCH_UADDR;
                    end
                end
                default: begin
                    if (!dma_req) begin
                        state_q <= RUN;
                        dma_ack_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign u_addr = u_addr_q;
    assign cw = cw_q;
    assign dma_ack = dma_ack_q;
    assign halted = halted_q;

`ifdef USEQ_TRACE_EN
    logic [31:0]         trace_cycles_q;
    logic [U_ADDR_W-1:0] trace_last_target_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_cycles_q <= '0;
            trace_last_target_q <= '0;
        end else begin
            if (state_q == RUN && trace_cycles_q != '1) trace_cycles_q <= trace_cycles_q + 32'd1;
            if ((state_q == RUN || state_q == STALL) && !hold && typ == 2'b01 && cond)
                trace_last_target_q <= rel;
        end
    end

    assign trace_cycles = trace_cycles_q;
    assign trace_last_target = trace_last_target_q;
`endif
endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Microcode sequencer for the Sol-1 CPU.
- Registers the 112-bit control word read from the microcode ROM bank, then computes the next microcode address from the typ/offset/cond/escape fields, the opcode in IR and the flag sources.
- Sits directly upstream of every consumer of the control word; drives the microcode ROM address bus.

Parameters:
- U_ADDR_W, 14, microcode address width (opcode page × 64 steps + escape page bit).
- CW_W, 112, control word width (14 ROMs × 8).
- FETCH_UADDR, 14'h0000, entry address of the fetch routine.
- INT_UADDR, 14'h0010, entry address of the interrupt-entry routine.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rom_cw  in  CW_W  control word read from microcode ROM at u_addr
- ir  in  8  instruction register (opcode)
- alu_flags  in  4  status flags {of,sf,cf,zf} (bits 3..0)
- u_flags  in  4  microcode flags {u_of,u_sf,u_cf,u_zf}
- cpu_status  in  8  status register (bit1 irq_en, bit4 halt)
- irq_req  in  1  pending masked interrupt
- dma_req  in  1  DMA request
- mem_wait  in  1  memory not ready; stall
- u_addr  out  U_ADDR_W  microcode ROM address
- cw  out  CW_W  registered control word to datapath
- dma_ack  out  1  bus granted to DMA
- halted  out  1  sequencer in HALT state

Behaviour:
- Reset (async, rst=1):
  - u_addr=FETCH_UADDR; cw=0 (no writes, no rd/wr); dma_ack=0; halted=0; state=RUN.
  - Reset mid-operation abandons the current routine immediately.
- Pipeline: cw <= rom_cw on every RUN clock edge.
  - ROM is combinational on u_addr, so cw reflects u_addr from the previous cycle.
  - Latency u_addr→cw is 1 clock.
- Next-address decode uses registered cw fields:
  - typ = cw[1:0]
  - off = cw[8:2], 7-bit two's complement
  - cond_invert = cw[9]; cond_flag_src = cw[10]; cond_sel = cw[14:11]; escape = cw[15]
- cond_sel (flag set = alu_flags if cond_flag_src=0, else u_flags):
  - 0 zf
  - 1 cf
  - 2 sf
  - 3 of
  - 4 sf^of
  - 5 zf|(sf^of)
  - 6 cf|zf
  - 7 dma_req
  - 8 cpu_status[4] (halt)
  - 9 irq_req & cpu_status[1]
  - 10–15 constant 0
- Result: cond = sel_value ^ cond_invert.
- typ decode:
  - 00 (offset): u_addr <= u_addr + sext(off).
  - 01 (branch): u_addr <= cond ? u_addr + sext(off) : u_addr + 1.
  - 10 (fetch): if irq_req & cpu_status[1], go to INT_UADDR; else go to FETCH_UADDR.
  - 11 (dispatch): u_addr <= {escape, ir, 6'b0} truncated/zero-extended to U_ADDR_W (escape selects the upper 16K half when U_ADDR_W>14; at 14 escape maps to bit 13 and ir[7] is dropped).
- Arithmetic is modulo 2^U_ADDR_W; wrap at 0x3FFF→0x0000 and 0x0000−1→0x3FFF is legal and unflagged.
- States:
  - RUN: normal sequencing.
  - STALL: entered when mem_wait=1 while cw rd or wr bit (cw[54] or cw[55]) is set. u_addr and cw are held. Returns to RUN on the first cycle mem_wait=0, then advances.
  - HALT: entered from typ=10 when cpu_status[4]=1. u_addr=FETCH_UADDR held; halted=1; cw forced to 0. Exit to RUN when irq_req & cpu_status[1] (u_addr=INT_UADDR) or when cpu_status[4] clears.
  - DMA: entered from typ=10 when dma_req=1. dma_req has priority over irq, and both over halt. In DMA, dma_ack=1, cw=0, u_addr held at FETCH_UADDR. On dma_req=0, dma_ack drops and the sequencer returns to RUN.
- Simultaneous events:
  - mem_wait during typ=10 with no rd/wr set: no stall.
  - rst always wins over all other inputs.

Optional Feature:
- USEQ_TRACE_EN: adds output ports trace_cycles (32 bits) and trace_last_target (U_ADDR_W bits).
  - trace_cycles counts RUN-state clocks, saturating at 0xFFFFFFFF; reset 0.
  - trace_last_target captures the destination of every taken typ=01 branch; reset 0.
- Without the macro, neither port nor its logic exists.

Test Plan:
- Release reset with rom_cw typ=11, ir=8'h2A, escape=0 → cycle 1 u_addr=0, cw loaded; cycle 2 u_addr=14'h0A80.
- typ=01, cond_sel=0, flag_src=0, alu_flags zf=1, off=7'h7E (−2), u_addr=0x0105 → next 0x0103; same stimulus with cond_invert=1 → 0x0106.
- typ=00, off=7'h7F at u_addr=0x0000 → 0x3FFF (wrap).
- typ=10, irq_req=1, cpu_status=8'h02 → u_addr=INT_UADDR (0x0010); with cpu_status=8'h10 and irq_req=0 → HALT, halted=1, cw=0, held until cpu_status bit4 clears.
- cw rd bit set, mem_wait high 3 cycles → u_addr and cw unchanged for 3 cycles, advance on 4th; dma_req during typ=10 → dma_ack=1 next cycle, cw=0, released one cycle after dma_req falls.
- Assert rst mid-STALL → u_addr=0, cw=0, dma_ack=0 immediately, without waiting for a clock edge.
